// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, oversample ratio and
// the baud-divisor to tick-divisor conversion.
package uart_pkg;

  localparam int OVERSAMPLE     = 16;
  localparam int OS_W           = $clog2(OVERSAMPLE);
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Clocks per oversample tick; a divisor below 16 still yields one tick per clock.
  function automatic logic [15:0] calc_tick_div(input logic [15:0] brd);
    logic [15:0] div;
    div = brd >> OS_W;
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with occupancy count; pointers wrap modulo DEPTH
// (DEPTH must be a power of two, at least 2).
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers bytes, divides the baud clock into 16x
// ticks and frames start/data/parity/stop bits onto a registered tx line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [15:0]                   brd,
  input  logic                          tx_en,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int IDX_W = $clog2(DATA_W);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] head;
  logic              parity_acc;
  logic [IDX_W-1:0]  bit_idx;
  logic [15:0]       tick_div;
  logic [15:0]       tick_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic              par_en_q;
  logic              par_odd_q;
  logic              two_stop_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic tick;
  logic bit_end;
  logic last_data;
  logic last_stop;
  logic can_start;

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (tx_data),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign push      = tx_valid && tx_ready;
  assign tx_busy   = (state != IDLE) || (fifo_count != '0);

  assign tick      = (state != IDLE) && (tick_cnt == tick_div - 16'd1);
  assign bit_end   = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_W - 1));
  assign last_stop = !two_stop_q || bit_idx[0];
  assign can_start = tx_en && !fifo_empty;

  // A new frame starts from IDLE or straight out of the final stop bit.
  assign pop = can_start &&
               ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_start) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = can_start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      parity_acc <= 1'b0;
      bit_idx    <= '0;
      tick_div   <= 16'd1;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shift      <= head;
        parity_acc <= 1'b0;
        bit_idx    <= '0;
        tick_div   <= calc_tick_div(brd);
        par_en_q   <= parity_en;
        par_odd_q  <= parity_odd;
        two_stop_q <= two_stop;
      end else if (bit_end) begin
        case (state)
          DATA: begin
            shift      <= shift >> 1;
            parity_acc <= parity_acc ^ shift[0];
            bit_idx    <= last_data ? '0 : bit_idx + 1'b1;
          end
          STOP:    bit_idx <= bit_idx + 1'b1;
          default: bit_idx <= bit_idx;
        endcase
      end
    end
  end

  // Tick and oversample counters both restart at every frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      os_cnt   <= os_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // Registered line driver: follows the state one clock later, so every
  // bit keeps its full period and back-to-back frames abut cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_out <= 1'b1;
    end else begin
      case (state)
        START:   tx_out <= 1'b0;
        DATA:    tx_out <= shift[0];
        PARITY:  tx_out <= parity_acc ^ par_odd_q;
        default: tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: expected serial frames are built from
// the framing rules (bit list x bit period) and compared on the falling edge.
module tb_uart_tx_ctrl;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] brd;
  logic        tx_en;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_out;
  logic        tx_busy;
  logic [2:0]  fifo_count;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic        busy_penult;
  logic        busy_last;

  uart_tx_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .brd        (brd),
    .tx_en      (tx_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit period in clocks from the divisor rule.
  function automatic int period_of(input logic [15:0] b);
    int d;
    d = int'(b) / 16;
    return 16 * ((d == 0) ? 1 : d);
  endfunction

  function automatic int frame_len(input bit pe, input bit ts);
    return 1 + DATA_W + (pe ? 1 : 0) + (ts ? 2 : 1);
  endfunction

  // Called on a falling edge; push lands on the next rising edge if tx_ready.
  task automatic push_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks the first and last clock of
  // every bit of the expected frame. Returns on the last stop-bit clock.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int p,
                              input bit pe, input bit po, input bit ts,
                              input int max_wait, output int unsigned start_c);
    bit bits [12];
    int nb;
    int w;
    nb = 0;
    bits[nb] = 1'b0; nb = nb + 1;
    for (int i = 0; i < DATA_W; i++) begin
      bits[nb] = d[i]; nb = nb + 1;
    end
    if (pe) begin
      bits[nb] = (($countones(d) % 2) != 0) ^ po; nb = nb + 1;
    end
    bits[nb] = 1'b1; nb = nb + 1;
    if (ts) begin
      bits[nb] = 1'b1; nb = nb + 1;
    end
    w = 0;
    while (tx_out !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    start_c = cyc;
    check({tag, " start_bit_seen"}, tx_out, 1'b0);
    if (tx_out !== 1'b0) return;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        if (!(b == 0 && k == 0)) @(negedge clk);
        if (k == 0 || k == p - 1)
          check($sformatf("%s bit%0d %s", tag, b, (k == 0) ? "first" : "last"), tx_out, bits[b]);
        if (b == nb - 1 && k == p - 2) busy_penult = tx_busy;
      end
    end
    busy_last = tx_busy;
  endtask

  initial begin
    int unsigned s0;
    int unsigned s1;
    int          p;
    int          n;
    bit          pe;
    bit          po;
    bit          ts;
    bit          stayed;
    logic [7:0]  q [$];
    logic [7:0]  b0;
    logic [7:0]  b1;

    reset_n    = 1'b0;
    brd        = 16'd16;
    tx_en      = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx_out", tx_out, 1'b1);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset tx_ready", tx_ready, 1'b1);
    check("reset fifo_count", fifo_count, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, latency, brd change ignored mid-frame, busy timing.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("lat fifo_count after push", fifo_count, 3'd1);
    check("lat tx_out edge N", tx_out, 1'b1);
    @(negedge clk);
    check("lat tx_out edge N+1", tx_out, 1'b1);
    check("lat tx_busy edge N+1", tx_busy, 1'b1);
    @(negedge clk);
    check("lat tx_out edge N+2", tx_out, 1'b0);
    brd = 16'hFFFF;
    expect_frame("a5", 8'hA5, 16, 1'b0, 1'b0, 1'b0, 2, s0);
    check("a5 busy before last clock", busy_penult, 1'b1);
    check("a5 busy dropped at 160", busy_last, 1'b0);
    brd = 16'd32;
    repeat (5) @(negedge clk);

    // Parity frames at 32 clocks per bit.
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    push_byte(8'h07);
    expect_frame("even 07", 8'h07, 32, 1'b1, 1'b0, 1'b0, 4, s0);
    check("even 07 busy dropped at 352", busy_last, 1'b0);
    check("even 07 busy before last", busy_penult, 1'b1);
    parity_odd = 1'b1;
    push_byte(8'h07);
    expect_frame("odd 07", 8'h07, 32, 1'b1, 1'b1, 1'b0, 4, s0);
    repeat (5) @(negedge clk);

    // FIFO fill with tx_en low, fifth byte held off, then back-to-back drain.
    parity_en = 1'b0;
    brd       = 16'd16;
    tx_en     = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("full fifo_count", fifo_count, 3'd4);
    check("full tx_ready", tx_ready, 1'b0);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    check("full fifth ignored", fifo_count, 3'd4);
    stayed = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b1) stayed = 1'b0;
    end
    check("tx_en=0 line idle and busy", stayed, 1'b1);
    tx_en = 1'b1;
    @(negedge clk);
    check("en raise pop count", fifo_count, 3'd3);
    check("en raise tx_ready", tx_ready, 1'b1);
    check("en raise tx_out still high", tx_out, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("fifth byte accepted", fifo_count, 3'd4);
    check("en raise tx_out low", tx_out, 1'b0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    s1 = 0;
    foreach (q[i]) begin
      expect_frame($sformatf("b2b%0d", i), q[i], 16, 1'b0, 1'b0, 1'b0, (i == 0) ? 2 : 3, s0);
      if (i != 0) check($sformatf("b2b%0d no gap", i), s0, s1 + 160);
      s1 = s0;
    end
    repeat (3) @(negedge clk);
    check("b2b drained busy", tx_busy, 1'b0);

    // Two stop bits: next start exactly 32 clocks after the last data bit.
    two_stop = 1'b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    push_byte(b0);
    push_byte(b1);
    expect_frame("2stop a", b0, 16, 1'b0, 1'b0, 1'b1, 4, s1);
    expect_frame("2stop b", b1, 16, 1'b0, 1'b0, 1'b1, 3, s0);
    check("2stop gap", s0, s1 + 176);
    two_stop = 1'b0;
    repeat (5) @(negedge clk);

    // tx_en dropped mid-DATA: frame completes, second byte waits.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    push_byte(b0);
    push_byte(b1);
    fork
      expect_frame("en drop a", b0, 16, 1'b0, 1'b0, 1'b0, 4, s0);
      begin
        repeat (70) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    stayed = 1'b1;
    repeat (64) begin
      @(negedge clk);
      if (tx_out !== 1'b1) stayed = 1'b0;
    end
    check("en drop line idle", stayed, 1'b1);
    check("en drop byte waiting", fifo_count, 3'd1);
    check("en drop busy", tx_busy, 1'b1);
    tx_en = 1'b1;
    expect_frame("en drop b", b1, 16, 1'b0, 1'b0, 1'b0, 3, s0);
    repeat (5) @(negedge clk);

    // Randomized batches against the framing model.
    for (int it = 0; it < 6; it++) begin
      if (it == 0) brd = 16'($urandom_range(0, 15));
      else         brd = 16'(16 * $urandom_range(1, 3) + $urandom_range(0, 15));
      p  = period_of(brd);
      pe = 1'($urandom);
      po = 1'($urandom);
      ts = 1'($urandom);
      parity_en  = pe;
      parity_odd = po;
      two_stop   = ts;
      n  = $urandom_range(1, 3);
      q.delete();
      for (int j = 0; j < n; j++) begin
        q.push_back(8'($urandom));
        push_byte(q[j]);
      end
      s1 = 0;
      foreach (q[j]) begin
        expect_frame($sformatf("rnd%0d.%0d", it, j), q[j], p, pe, po, ts, 8, s0);
        if (j != 0) check($sformatf("rnd%0d.%0d no gap", it, j), s0, s1 + frame_len(pe, ts) * p);
        s1 = s0;
      end
      repeat (3) @(negedge clk);
      check($sformatf("rnd%0d idle", it), tx_busy, 1'b0);
    end

    // Asynchronous reset mid-DATA.
    brd        = 16'd16;
    parity_en  = 1'b0;
    two_stop   = 1'b0;
    push_byte(8'h00);
    push_byte(8'hFF);
    for (int w = 0; w < 8 && tx_out !== 1'b0; w++) @(negedge clk);
    repeat (40) @(negedge clk);
    check("pre-reset line low in data", tx_out, 1'b0);
    check("pre-reset queued", fifo_count, 3'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset tx_out", tx_out, 1'b1);
    check("async reset fifo_count", fifo_count, 3'd0);
    check("async reset tx_busy", tx_busy, 1'b0);
    check("async reset tx_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stayed = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) stayed = 1'b0;
    end
    check("no residual frame after reset", stayed, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
